// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin-slot front end: sync, debounce, per-coin queue, spaced single-cycle pulses
//
// Ports:
//   sys_clk        in   system clock
//   sys_rst_n      in   asynchronous active-low reset
//   coin_one_n     in   raw 1-yuan slot sensor, 0 = coin present, bounces
//   coin_half_n    in   raw 0.5-yuan slot sensor, 0 = coin present, bounces
//   po_money_one   out  one-cycle registered pulse per accepted 1-yuan coin
//   po_money_half  out  one-cycle registered pulse per accepted 0.5-yuan coin
`timescale 1ns/1ps

module coin_acceptor #(
    parameter logic [19:0] CNT_MAX = 20'd999_999,
    parameter logic [7:0]  GAP_CYC = 8'd1,
    parameter int          PEND_W  = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic coin_one_n,
    input  logic coin_half_n,
    output logic po_money_one,
    output logic po_money_half
);

    // Slot indices used for the per-sensor arrays.
    localparam int ONE  = 0;
    localparam int HALF = 1;

    localparam logic [19:0] CNT_TOP = CNT_MAX - 20'd1;
    localparam logic [19:0] CNT_PRE = CNT_MAX - 20'd2;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_INC = PEND_W'(1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_EMIT_ONE  = 2'd1;
    localparam logic [1:0] ST_EMIT_HALF = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    localparam logic RR_ONE  = 1'b0;
    localparam logic RR_HALF = 1'b1;

    // ------------------------------------------------------------------
    // Synchroniser: two flops per sensor, released level = 1.
    // ------------------------------------------------------------------
    logic [1:0] coin_raw_n;
    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;

    assign coin_raw_n = {coin_half_n, coin_one_n};

    always_comb begin
        sync1_d = coin_raw_n;
        sync2_d = sync1_q;
    end

    // ------------------------------------------------------------------
    // Debounce: count consecutive low cycles of the synced level. The
    // counter parks at CNT_MAX-1, so det fires only once per low period;
    // any high cycle clears it and a fresh full-length low is required.
    // ------------------------------------------------------------------
    logic [19:0] cnt_q [2];
    logic [19:0] cnt_d [2];
    logic [1:0]  det_q, det_d;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i]) begin
                cnt_d[i] = 20'd0;
            end else if (cnt_q[i] == CNT_TOP) begin
                cnt_d[i] = cnt_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 20'd1;
            end
            // Registered, so det is high on the first cycle the count
            // sits at CNT_MAX-1.
            det_d[i] = ~sync2_q[i] && (cnt_q[i] == CNT_PRE);
        end
    end

    // ------------------------------------------------------------------
    // Pending counters and emit FSM.
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [7:0]        gap_q, gap_d;
    logic              rr_last_q, rr_last_d;
    logic [PEND_W-1:0] pend_one_q, pend_one_d;
    logic [PEND_W-1:0] pend_half_q, pend_half_d;
    logic              po_one_q, po_one_d;
    logic              po_half_q, po_half_d;
    logic              req_one, req_half;
    logic              issue_one, issue_half;

    // A coin counts as issued on its EMIT cycle; a det landing on that
    // same cycle simply replaces it, and a det into a full queue is lost.
    function automatic logic [PEND_W-1:0] pend_next(
        input logic [PEND_W-1:0] cur,
        input logic              inc,
        input logic              dec
    );
        pend_next = cur;
        if (inc && !dec) begin
            if (cur != PEND_MAX) begin
                pend_next = cur + PEND_INC;
            end
        end else if (dec && !inc) begin
            if (cur != '0) begin
                pend_next = cur - PEND_INC;
            end
        end
    endfunction

    always_comb begin
        issue_one   = (state_q == ST_EMIT_ONE);
        issue_half  = (state_q == ST_EMIT_HALF);
        pend_one_d  = pend_next(pend_one_q, det_q[ONE], issue_one);
        pend_half_d = pend_next(pend_half_q, det_q[HALF], issue_half);
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        rr_last_d = rr_last_q;
        // A det arriving while idle is served at once; the counter picks
        // it up the same edge and the EMIT cycle takes it back out.
        req_one   = (pend_one_q != '0) || det_q[ONE];
        req_half  = (pend_half_q != '0) || det_q[HALF];

        case (state_q)
            ST_IDLE: begin
                if (req_one && (!req_half || rr_last_q == RR_HALF)) begin
                    state_d = ST_EMIT_ONE;
                end else if (req_half) begin
                    state_d = ST_EMIT_HALF;
                end
            end
            ST_EMIT_ONE: begin
                rr_last_d = RR_ONE;
                state_d   = ST_GAP;
                gap_d     = GAP_CYC;
            end
            ST_EMIT_HALF: begin
                rr_last_d = RR_HALF;
                state_d   = ST_GAP;
                gap_d     = GAP_CYC;
            end
            ST_GAP: begin
                // Stays here exactly GAP_CYC cycles.
                if (gap_q <= 8'd1) begin
                    state_d = ST_IDLE;
                    gap_d   = 8'd0;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gap_d   = 8'd0;
            end
        endcase

        // Outputs decoded from the next state so they are high exactly
        // while the FSM sits in an EMIT state.
        po_one_d  = (state_d == ST_EMIT_ONE);
        po_half_d = (state_d == ST_EMIT_HALF);
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            cnt_q[0]    <= 20'd0;
            cnt_q[1]    <= 20'd0;
            det_q       <= 2'b00;
            state_q     <= ST_IDLE;
            gap_q       <= 8'd0;
            rr_last_q   <= RR_HALF;
            pend_one_q  <= '0;
            pend_half_q <= '0;
            po_one_q    <= 1'b0;
            po_half_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            det_q       <= det_d;
            state_q     <= state_d;
            gap_q       <= gap_d;
            rr_last_q   <= rr_last_d;
            pend_one_q  <= pend_one_d;
            pend_half_q <= pend_half_d;
            po_one_q    <= po_one_d;
            po_half_q   <= po_half_d;
        end
    end

    assign po_money_one  = po_one_q;
    assign po_money_half = po_half_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - self-checking bench for coin_acceptor (GAP_CYC=1 and GAP_CYC=100 instances)
`timescale 1ns/1ps

module tb_coin_acceptor;

    localparam int CNT  = 4;
    localparam int PMAX = 3;
    localparam int NI   = 2;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       one_n  = 1'b1;
    logic       half_n = 1'b1;
    logic [1:0] po_one;
    logic [1:0] po_half;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    coin_acceptor #(.CNT_MAX(20'd4), .GAP_CYC(8'd1), .PEND_W(2)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .coin_one_n(one_n), .coin_half_n(half_n),
        .po_money_one(po_one[0]), .po_money_half(po_half[0]));

    coin_acceptor #(.CNT_MAX(20'd4), .GAP_CYC(8'd100), .PEND_W(2)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .coin_one_n(one_n), .coin_half_n(half_n),
        .po_money_one(po_one[1]), .po_money_half(po_half[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gap_of(input int n);
        return (n == 0) ? 1 : 100;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: a coin is detected when the synced level (raw delayed two
    // edges) has been low for CNT-1 consecutive edges; each instance then
    // serves queued coins round-robin with a cool-down of GAP+1 edges.
    bit r1 [2];
    bit r2 [2];
    int run [2];
    bit det [2];
    int pend [NI][2];
    int cool [NI];
    int last [NI];
    bit mpo [NI][2];

    always @(posedge clk or negedge rst_n) begin : model
        bit raw [2];
        bit ndet [2];
        bit issue [2];
        bit want [2];
        int pick;
        int pb;
        if (!rst_n) begin
            for (int t = 0; t < 2; t++) begin
                r1[t] = 1; r2[t] = 1; run[t] = 0; det[t] = 0;
            end
            for (int n = 0; n < NI; n++) begin
                cool[n] = 0; last[n] = 1;
                for (int t = 0; t < 2; t++) begin
                    pend[n][t] = 0; mpo[n][t] = 0;
                end
            end
        end else begin
            raw[0] = one_n;
            raw[1] = half_n;
            for (int t = 0; t < 2; t++) begin
                if (r2[t]) run[t] = 0; else run[t] = run[t] + 1;
                ndet[t] = !r2[t] && (run[t] == CNT - 1);
                r2[t] = r1[t];
                r1[t] = raw[t];
            end
            for (int n = 0; n < NI; n++) begin
                issue[0] = mpo[n][0];
                issue[1] = mpo[n][1];
                pick = -1;
                if (cool[n] > 0) begin
                    cool[n] = cool[n] - 1;
                end else begin
                    for (int t = 0; t < 2; t++) want[t] = (pend[n][t] > 0) || det[t];
                    if (want[0] && want[1]) pick = 1 - last[n];
                    else if (want[0]) pick = 0;
                    else if (want[1]) pick = 1;
                    if (pick >= 0) begin
                        last[n] = pick;
                        cool[n] = gap_of(n) + 1;
                    end
                end
                for (int t = 0; t < 2; t++) begin
                    pb = pend[n][t];
                    if (issue[t]) pend[n][t] = pend[n][t] - 1;
                    if (det[t] && !(pb == PMAX && !issue[t])) pend[n][t] = pend[n][t] + 1;
                end
                mpo[n][0] = (pick == 0);
                mpo[n][1] = (pick == 1);
            end
            for (int t = 0; t < 2; t++) det[t] = ndet[t];
        end
    end

    typedef struct {
        int inst;
        int kind;
        int t;
    } ev_s;
    ev_s evq[$];

    always @(negedge clk) begin
        for (int n = 0; n < NI; n++) begin
            check($sformatf("po_one_vs_model[%0d]", n), int'(po_one[n]), int'(mpo[n][0]));
            check($sformatf("po_half_vs_model[%0d]", n), int'(po_half[n]), int'(mpo[n][1]));
            check($sformatf("exclusive[%0d]", n), int'(po_one[n] & po_half[n]), 0);
            if (po_one[n]) evq.push_back('{n, 0, cyc});
            if (po_half[n]) evq.push_back('{n, 1, cyc});
        end
    end

    function automatic int n_ev(input int inst, input int kind, input int after);
        int c = 0;
        foreach (evq[i])
            if (evq[i].inst == inst && (kind < 0 || evq[i].kind == kind) && evq[i].t > after) c++;
        return c;
    endfunction

    function automatic int ev_time(input int inst, input int idx);
        int k = 0;
        foreach (evq[i]) begin
            if (evq[i].inst == inst) begin
                if (k == idx) return evq[i].t;
                k++;
            end
        end
        return -1;
    endfunction

    function automatic int ev_kind(input int inst, input int idx);
        int k = 0;
        foreach (evq[i]) begin
            if (evq[i].inst == inst) begin
                if (k == idx) return evq[i].kind;
                k++;
            end
        end
        return -1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic coin(input int which, input int low, input int high);
        if (which == 0) one_n = 1'b0; else half_n = 1'b0;
        wait_cyc(low);
        if (which == 0) one_n = 1'b1; else half_n = 1'b1;
        wait_cyc(high);
    endtask

    int c0;
    int rel;

    initial begin
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        for (int n = 0; n < NI; n++) begin
            check("reset_po_one", int'(po_one[n]), 0);
            check("reset_po_half", int'(po_half[n]), 0);
        end

        // 1: single half coin, 10 low cycles
        evq.delete();
        c0 = cyc;
        half_n = 1'b0;
        wait_cyc(10);
        half_n = 1'b1;
        wait_cyc(20);
        for (int n = 0; n < NI; n++) begin
            check("t1_half_count", n_ev(n, 1, -1), 1);
            check("t1_one_count", n_ev(n, 0, -1), 0);
            check("t1_latency", ev_time(n, 0) - c0, 6);
        end
        wait_cyc(120);

        // 2: bouncing one sensor, never 4 stable lows
        evq.delete();
        repeat (4) begin
            one_n = 1'b0; wait_cyc(2);
            one_n = 1'b1; wait_cyc(2);
        end
        wait_cyc(20);
        for (int n = 0; n < NI; n++) check("t2_no_pulse", n_ev(n, -1, -1), 0);

        // 3: both sensors fall together
        evq.delete();
        c0 = cyc;
        one_n = 1'b0; half_n = 1'b0;
        wait_cyc(10);
        one_n = 1'b1; half_n = 1'b1;
        wait_cyc(150);
        for (int n = 0; n < NI; n++) begin
            check("t3_count", n_ev(n, -1, -1), 2);
            check("t3_first_kind", ev_kind(n, 0), 0);
            check("t3_second_kind", ev_kind(n, 1), 1);
            check("t3_first_time", ev_time(n, 0) - c0, 6);
            check("t3_spacing", ev_time(n, 1) - ev_time(n, 0), gap_of(n) + 2);
        end
        wait_cyc(120);

        // 4: six half coins, queue saturates on the slow instance
        evq.delete();
        repeat (6) coin(1, 6, 4);
        wait_cyc(300);
        check("t4_fast_count", n_ev(0, 1, -1), 6);
        check("t4_slow_count", n_ev(1, 1, -1), 4);
        for (int k = 0; k < 3; k++)
            check("t4_slow_spacing", ev_time(1, k + 1) - ev_time(1, k), 102);
        wait_cyc(120);

        // 5: reset while two one-coins are queued during GAP
        evq.delete();
        repeat (3) coin(0, 6, 4);
        wait_cyc(2);
        check("t5_fast_before", n_ev(0, 0, -1), 3);
        check("t5_slow_before", n_ev(1, 0, -1), 1);
        rst_n = 1'b0;
        #1;
        for (int n = 0; n < NI; n++) begin
            check("t5_reset_one", int'(po_one[n]), 0);
            check("t5_reset_half", int'(po_half[n]), 0);
        end
        wait_cyc(1);
        rst_n = 1'b1;
        rel = cyc;
        wait_cyc(250);
        for (int n = 0; n < NI; n++) check("t5_after_reset", n_ev(n, -1, rel), 0);
        evq.delete();
        coin(0, 6, 4);
        wait_cyc(20);
        for (int n = 0; n < NI; n++) check("t5_new_coin", n_ev(n, 0, -1), 1);
        wait_cyc(120);

        // 6: alternating coins, order must alternate
        evq.delete();
        repeat (3) begin
            coin(0, 6, 4);
            coin(1, 6, 4);
        end
        wait_cyc(600);
        for (int n = 0; n < NI; n++) begin
            check("t6_count", n_ev(n, -1, -1), 6);
            for (int k = 0; k < 6; k++) check("t6_order", ev_kind(n, k), k % 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
